// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Sequences the IF/ID front end around the instruction decoder:
//   - stalls fetch/decode for a load-use hazard against the EX-stage load
//   - redirects the PC for J/JAL (target computed in ID)
//   - holds fetch while EX resolves conditional branches and JR/JALR
//   - drives PC write, IF/ID write/flush and ID/EX bubble controls
//
// Parameters
//   LOAD_STALL_CYCLES  total stall cycles per load-use hazard (1..7)
//   BR_TIMEOUT         max cycles spent waiting in S_BRANCH (1..255)
//   STALL_CNT_W        width of the saturating stall-cycle counter
//
// Ports
//   i_clk, i_rst         clock / synchronous active-high reset
//   i_id_rs, i_id_rt     operand fields of the instruction in ID
//   i_id_uses_rt         ID instruction reads rt
//   i_id_pc_modify       ID instruction changes the PC
//   i_id_addr_type       00 register, 01 J-target, 10 branch
//   i_ex_mem_op          EX instruction is a memory op
//   i_ex_mem_type        0 load, 1 store
//   i_ex_rt              EX load destination register
//   i_br_resolved        EX resolved branch/JR this cycle (pulse)
//   i_br_taken           branch outcome, valid with i_br_resolved
//   i_dbg_step_mode      (DBG_STEP_EN only) single-step mode enable
//   i_dbg_step           (DBG_STEP_EN only) execute one cycle
//   o_pc_write           PC updates
//   o_pc_src_jump        select J/JAL target from ID
//   o_pc_src_branch      select EX branch/JR target
//   o_ifid_write         IF/ID latch loads
//   o_ifid_flush         IF/ID loads NOP
//   o_idex_bubble        ID/EX loads NOP
//   o_pipe_en            global enable for later stages
//   o_state              S_RUN=0, S_LOAD_STALL=1, S_BRANCH=2, S_HALT=3
//   o_stall_cnt          saturating count of cycles with o_pc_write==0
//   o_br_timeout         one-cycle pulse when a branch wait times out
//
// Optional feature: define DBG_STEP_EN to add the single-step debug ports.
// Without it the debug ports are absent, o_pipe_en is tied high and S_HALT
// is never reported.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned BR_TIMEOUT        = 15,
  parameter int unsigned STALL_CNT_W       = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [4:0]             i_id_rs,
  input  logic [4:0]             i_id_rt,
  input  logic                   i_id_uses_rt,
  input  logic                   i_id_pc_modify,
  input  logic [1:0]             i_id_addr_type,
  input  logic                   i_ex_mem_op,
  input  logic                   i_ex_mem_type,
  input  logic [4:0]             i_ex_rt,
  input  logic                   i_br_resolved,
  input  logic                   i_br_taken,
`ifdef DBG_STEP_EN
  input  logic                   i_dbg_step_mode,
  input  logic                   i_dbg_step,
`endif
  output logic                   o_pc_write,
  output logic                   o_pc_src_jump,
  output logic                   o_pc_src_branch,
  output logic                   o_ifid_write,
  output logic                   o_ifid_flush,
  output logic                   o_idex_bubble,
  output logic                   o_pipe_en,
  output logic [1:0]             o_state,
  output logic [STALL_CNT_W-1:0] o_stall_cnt,
  output logic                   o_br_timeout
);

  localparam logic [1:0] S_RUN        = 2'd0;
  localparam logic [1:0] S_LOAD_STALL = 2'd1;
  localparam logic [1:0] S_BRANCH     = 2'd2;
  localparam logic [1:0] S_HALT       = 2'd3;

  // The first stall cycle is spent in S_RUN, so S_LOAD_STALL only covers
  // the remaining LOAD_STALL_CYCLES-1 cycles.
  localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 1);
  localparam logic [2:0] STALL_INIT  = 3'(LOAD_STALL_CYCLES - 1);
  // Timer counts completed wait cycles; the BR_TIMEOUT-th cycle is the last.
  localparam logic [7:0] TMO_LAST    = 8'(BR_TIMEOUT - 1);

  logic [1:0]             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             timer_q, timer_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Nominal (un-gated) control outputs of the FSM
  logic nom_pc_write;
  logic nom_pc_src_jump;
  logic nom_pc_src_branch;
  logic nom_ifid_write;
  logic nom_ifid_flush;
  logic nom_idex_bubble;
  logic nom_br_timeout;

  logic hazard;
  logic halt;

`ifdef DBG_STEP_EN
  // Halted whenever step mode is on and no step is requested this cycle.
  assign halt = i_dbg_step_mode & ~i_dbg_step;
`else
  assign halt = 1'b0;
`endif

  // Load-use hazard; r0 is hard-wired zero so it never creates a dependency.
  assign hazard = i_ex_mem_op & ~i_ex_mem_type & (i_ex_rt != 5'd0) &
                  ((i_ex_rt == i_id_rs) | (i_id_uses_rt & (i_ex_rt == i_id_rt)));

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    timer_d           = timer_q;
    nom_pc_write      = 1'b1;
    nom_pc_src_jump   = 1'b0;
    nom_pc_src_branch = 1'b0;
    nom_ifid_write    = 1'b1;
    nom_ifid_flush    = 1'b0;
    nom_idex_bubble   = 1'b0;
    nom_br_timeout    = 1'b0;

    case (state_q)
      S_RUN: begin
        if (hazard) begin
          // Stall wins over any control transfer; the ID instruction is
          // re-evaluated once the stall ends.
          nom_pc_write    = 1'b0;
          nom_ifid_write  = 1'b0;
          nom_idex_bubble = 1'b1;
          if (MULTI_STALL) begin
            cnt_d   = STALL_INIT;
            state_d = S_LOAD_STALL;
          end
        end else if (i_id_pc_modify && (i_id_addr_type == 2'b01)) begin
          nom_pc_src_jump = 1'b1;
          nom_ifid_flush  = 1'b1;
        end else if (i_id_pc_modify) begin
          // Branch/JR proceeds to EX; fetch waits for resolution.
          nom_pc_write   = 1'b0;
          nom_ifid_flush = 1'b1;
          timer_d        = 8'd0;
          state_d        = S_BRANCH;
        end
      end

      S_LOAD_STALL: begin
        nom_pc_write    = 1'b0;
        nom_ifid_write  = 1'b0;
        nom_idex_bubble = 1'b1;
        cnt_d           = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_RUN;
        end
      end

      S_BRANCH: begin
        nom_pc_write    = 1'b0;
        nom_ifid_flush  = 1'b1;
        nom_idex_bubble = 1'b1;
        timer_d         = timer_q + 8'd1;
        // A resolution arriving in the timeout cycle takes precedence.
        if (i_br_resolved) begin
          nom_pc_write      = 1'b1;
          nom_pc_src_branch = i_br_taken;
          state_d           = S_RUN;
        end else if (timer_q == TMO_LAST) begin
          nom_br_timeout = 1'b1;
          nom_pc_write   = 1'b1;
          state_d        = S_RUN;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Output stage: reset forces a safe pipeline, halt silences everything.
  always_comb begin
    o_pc_write      = nom_pc_write;
    o_pc_src_jump   = nom_pc_src_jump;
    o_pc_src_branch = nom_pc_src_branch;
    o_ifid_write    = nom_ifid_write;
    o_ifid_flush    = nom_ifid_flush;
    o_idex_bubble   = nom_idex_bubble;
    o_pipe_en       = 1'b1;
    o_br_timeout    = nom_br_timeout;
    o_state         = state_q;
    if (i_rst) begin
      o_pc_write      = 1'b0;
      o_pc_src_jump   = 1'b0;
      o_pc_src_branch = 1'b0;
      o_ifid_write    = 1'b0;
      o_ifid_flush    = 1'b1;
      o_idex_bubble   = 1'b1;
      o_br_timeout    = 1'b0;
    end else if (halt) begin
      o_pc_write      = 1'b0;
      o_pc_src_jump   = 1'b0;
      o_pc_src_branch = 1'b0;
      o_ifid_write    = 1'b0;
      o_ifid_flush    = 1'b0;
      o_idex_bubble   = 1'b0;
      o_pipe_en       = 1'b0;
      o_br_timeout    = 1'b0;
      o_state         = S_HALT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_RUN;
      cnt_q       <= 3'd0;
      timer_q     <= 8'd0;
      stall_cnt_q <= '0;
    end else if (!halt) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      // Saturate at all-ones rather than wrap.
      if (!nom_pc_write && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;

endmodule
